// File: rtl/mem_sched_if.sv
// Bus bundle between the memory scheduler, the cache miss ports and the main-memory port.
// master: the scheduler side; slave: the caches and memory it serves.
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 64
`endif

interface mem_sched_if #(
  parameter int unsigned WIDTH = `MEMORY_WIDTH
);
  logic             ic_read_req;
  logic [31:0]      ic_read_addr;
  logic             ic_read_ack;
  logic [WIDTH-1:0] ic_read_data;
  logic             dc_read_req;
  logic [31:0]      dc_read_addr;
  logic             dc_read_ack;
  logic [WIDTH-1:0] dc_read_data;
  logic             dc_write_req;
  logic [31:0]      dc_write_addr;
  logic [WIDTH-1:0] dc_write_data;
  logic             dc_write_ack;
  logic             mem_enable;
  logic             mem_rw;
  logic             mem_ack;
  logic [31:0]      mem_addr;
  logic [WIDTH-1:0] mem_data_in;
  logic [WIDTH-1:0] mem_data_out;
  logic             busy;
  logic             timeout_err;

  modport master (
    input  ic_read_req, ic_read_addr, dc_read_req, dc_read_addr,
           dc_write_req, dc_write_addr, dc_write_data, mem_ack, mem_data_out,
    output ic_read_ack, ic_read_data, dc_read_ack, dc_read_data, dc_write_ack,
           mem_enable, mem_rw, mem_addr, mem_data_in, busy, timeout_err
  );

  modport slave (
    output ic_read_req, ic_read_addr, dc_read_req, dc_read_addr,
           dc_write_req, dc_write_addr, dc_write_data, mem_ack, mem_data_out,
    input  ic_read_ack, ic_read_data, dc_read_ack, dc_read_data, dc_write_ack,
           mem_enable, mem_rw, mem_addr, mem_data_in, busy, timeout_err
  );
endinterface

// File: rtl/mem_scheduler.sv
// Round-robin arbiter sharing one main-memory port between I-cache fills, D-cache fills and
// D-cache write-backs, one transaction at a time, with a watchdog on unacknowledged accesses.
module mem_scheduler #(
  parameter int unsigned WIDTH   = `MEMORY_WIDTH,
  parameter int unsigned TIMEOUT = 255
) (
  input logic          clk,
  input logic          reset,
  mem_sched_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e           state_q;
  logic [1:0]       last_grant_q;
  logic [1:0]       grant_q;
  logic [31:0]      addr_q;
  logic             rw_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic [31:0]      wdog_q;
  logic             timeout_err_q;

  logic [2:0]  req;
  logic [1:0]  grant_d;
  logic [31:0] addr_sel;
  logic        wdog_expired;
  logic        in_issue;
  logic        in_resp;
  int          idx;

  assign req = {bus.dc_write_req, bus.dc_read_req, bus.ic_read_req};

  // Walk the rotation backwards so the candidate right after last_grant is written last and wins.
  always_comb begin
    grant_d = last_grant_q;
    idx     = 0;
    for (int i = 3; i >= 1; i--) begin
      idx = (int'(last_grant_q) + i) % 3;
      if (req[idx[1:0]]) grant_d = idx[1:0];
    end
  end

  always_comb begin
    unique case (grant_d)
      2'd0:    addr_sel = bus.ic_read_addr;
      2'd1:    addr_sel = bus.dc_read_addr;
      default: addr_sel = bus.dc_write_addr;
    endcase
  end

  assign wdog_expired = (TIMEOUT != 0) && (wdog_q == 32'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      last_grant_q  <= 2'd2;
      grant_q       <= 2'd0;
      addr_q        <= '0;
      rw_q          <= 1'b0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            addr_q       <= addr_sel;
            rw_q         <= (grant_d != 2'd2);
            wdata_q      <= (grant_d == 2'd2) ? bus.dc_write_data : '0;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          // A completion on the final watchdog cycle takes priority over the abort.
          if (bus.mem_ack) begin
            if (rw_q) rdata_q <= bus.mem_data_out;
            wdog_q  <= '0;
            state_q <= StResp;
          end else if (wdog_expired) begin
            rdata_q       <= '0;
            timeout_err_q <= 1'b1;
            wdog_q        <= '0;
            state_q       <= StResp;
          end else begin
            wdog_q <= wdog_q + 32'd1;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_issue = (state_q == StIssue);
  assign in_resp  = (state_q == StResp);

  assign bus.mem_enable   = in_issue;
  assign bus.mem_rw       = in_issue & rw_q;
  assign bus.mem_addr     = in_issue ? addr_q : '0;
  assign bus.mem_data_in  = in_issue ? wdata_q : '0;
  assign bus.ic_read_ack  = in_resp && (grant_q == 2'd0);
  assign bus.dc_read_ack  = in_resp && (grant_q == 2'd1);
  assign bus.dc_write_ack = in_resp && (grant_q == 2'd2);
  assign bus.ic_read_data = rdata_q;
  assign bus.dc_read_data = rdata_q;
  assign bus.busy         = (state_q != StIdle);
  assign bus.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_mem_scheduler.sv
// Directed and randomized bench for mem_scheduler against a transaction-level reference model.
module tb_mem_scheduler;
  localparam int unsigned W = 64;
  localparam int unsigned T = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  mem_sched_if #(.WIDTH(W)) bus ();

  mem_scheduler #(.WIDTH(W), .TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: who was served last, what the read-data register holds, sticky error.
  int             m_last;
  logic [W-1:0]   m_rdata;
  logic           m_terr;
  logic [31:0]    addr [3];
  logic [W-1:0]   wd;
  logic [W-1:0]   dout;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input int last, input logic [2:0] r);
    for (int i = 1; i <= 3; i++) begin
      if (r[(last + i) % 3]) return (last + i) % 3;
    end
    return -1;
  endfunction

  task automatic drive_reqs(input logic [2:0] r);
    bus.ic_read_req   = r[0];
    bus.dc_read_req   = r[1];
    bus.dc_write_req  = r[2];
    bus.ic_read_addr  = addr[0];
    bus.dc_read_addr  = addr[1];
    bus.dc_write_addr = addr[2];
    bus.dc_write_data = wd;
  endtask

  task automatic model_reset();
    m_last  = 2;
    m_rdata = '0;
    m_terr  = 1'b0;
  endtask

  function automatic logic [2:0] acks();
    return {bus.dc_write_ack, bus.dc_read_ack, bus.ic_read_ack};
  endfunction

  // One arbitration: IDLE cycle, ISSUE cycles until ack or abort, RESP cycle.
  // d = ISSUE cycles that pass before mem_ack is raised.
  task automatic do_txn(input logic [2:0] r, input int d, input bit drop_mid);
    int g, n;
    bit to;
    logic [31:0] e_addr;
    logic [W-1:0] e_wd;
    drive_reqs(r);
    bus.mem_ack      = 1'($urandom);
    bus.mem_data_out = {$urandom, $urandom};
    check("idle_busy", W'(bus.busy), W'(1'b0));
    check("idle_en", W'(bus.mem_enable), W'(1'b0));
    check("idle_acks", W'(acks()), W'(3'b000));
    check("idle_terr", W'(bus.timeout_err), W'(m_terr));
    if (r == 3'b000) begin
      step();
      return;
    end
    g      = rr_pick(m_last, r);
    m_last = g;
    e_addr = addr[g];
    e_wd   = wd;
    to     = (T != 0) && (d >= int'(T));
    n      = to ? int'(T) : d + 1;
    step();
    for (int i = 1; i <= n; i++) begin
      check("iss_en", W'(bus.mem_enable), W'(1'b1));
      check("iss_busy", W'(bus.busy), W'(1'b1));
      check("iss_acks", W'(acks()), W'(3'b000));
      check("iss_addr", W'(bus.mem_addr), W'(e_addr));
      check("iss_rw", W'(bus.mem_rw), W'(g != 2));
      if (g == 2) check("iss_wdata", bus.mem_data_in, e_wd);
      for (int k = 0; k < 3; k++) addr[k] = $urandom;
      wd = {$urandom, $urandom};
      if (drop_mid) r[g] = 1'b0;
      drive_reqs(r);
      bus.mem_ack      = (i == d + 1);
      bus.mem_data_out = (i == d + 1) ? dout : {$urandom, $urandom};
      step();
    end
    if (to) begin
      m_rdata = '0;
      m_terr  = 1'b1;
    end else if (g != 2) begin
      m_rdata = dout;
    end
    bus.mem_ack      = 1'($urandom);
    bus.mem_data_out = {$urandom, $urandom};
    check("resp_acks", W'(acks()), W'(3'b001 << g));
    check("resp_en", W'(bus.mem_enable), W'(1'b0));
    check("resp_busy", W'(bus.busy), W'(1'b1));
    check("resp_terr", W'(bus.timeout_err), W'(m_terr));
    if (g == 0) check("resp_ic_data", bus.ic_read_data, m_rdata);
    if (g == 1) check("resp_dc_data", bus.dc_read_data, m_rdata);
    step();
  endtask

  // Cycle-wide invariants: never enable and ack together, at most one ack.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      assert (!(bus.mem_enable && (|acks())) && $onehot0(acks()))
      else begin
        errors++;
        $error("FAIL ack_excl: observed en=%0b acks=%03b expected no overlap", bus.mem_enable,
               acks());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) addr[k] = '0;
    wd = '0;
    dout = '0;
    drive_reqs(3'b000);
    bus.mem_ack = 1'b0;
    bus.mem_data_out = '0;
    model_reset();

    // Reset state
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst_busy", W'(bus.busy), W'(1'b0));
    check("rst_en", W'(bus.mem_enable), W'(1'b0));
    check("rst_rw", W'(bus.mem_rw), W'(1'b0));
    check("rst_addr", W'(bus.mem_addr), W'(32'd0));
    check("rst_acks", W'(acks()), W'(3'b000));
    check("rst_rdata", bus.ic_read_data, '0);
    check("rst_terr", W'(bus.timeout_err), W'(1'b0));

    // Single I-cache fill from 0x40, memory answers on the third ISSUE cycle
    addr[0] = 32'h40;
    dout = {8{8'hA5}};
    do_txn(3'b001, 2, 1'b0);
    drive_reqs(3'b000);

    // All three held from reset: ic, dc_read, dc_write, ic
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 3; k++) addr[k] = $urandom;
      wd = {$urandom, $urandom};
      dout = {$urandom, $urandom};
      do_txn(3'b111, j % 2, 1'b0);
    end

    // Write-back to 0x100, acknowledged on the last cycle before the watchdog would fire
    addr[2] = 32'h100;
    wd = {4{16'hDEAD}};
    do_txn(3'b100, int'(T) - 1, 1'b0);

    // Memory never answers: abort after T ISSUE cycles, sticky error survives later traffic
    dout = {$urandom, $urandom};
    do_txn(3'b010, 50, 1'b0);
    dout = {$urandom, $urandom};
    do_txn(3'b001, 0, 1'b1);

    // mem_ack noise with nobody requesting
    for (int j = 0; j < 3; j++) do_txn(3'b000, 0, 1'b0);

    // Reset in the middle of ISSUE
    addr[1] = $urandom;
    drive_reqs(3'b010);
    step();
    bus.mem_ack = 1'b0;
    step();
    check("mid_en_pre", W'(bus.mem_enable), W'(1'b1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive_reqs(3'b000);
    model_reset();
    check("mid_busy", W'(bus.busy), W'(1'b0));
    check("mid_en", W'(bus.mem_enable), W'(1'b0));
    check("mid_acks", W'(acks()), W'(3'b000));
    check("mid_terr", W'(bus.timeout_err), W'(1'b0));
    step();
    check("mid_acks2", W'(acks()), W'(3'b000));

    // Randomized traffic
    for (int j = 0; j < 300; j++) begin
      for (int k = 0; k < 3; k++) addr[k] = $urandom;
      wd = {$urandom, $urandom};
      dout = {$urandom, $urandom};
      do_txn(3'($urandom), int'($urandom_range(0, 6)), ($urandom % 4) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
